// File: rtl/mask_encoder.sv
// Candidate-mask to digit encoder for a 4x4 board, with one-cycle valid/ready output stage.
// Optional per-board statistics are built when MASK_ENCODER_BOARD_STATS_EN is defined.
module mask_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_mask,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic [3:0] out_cell,
  output logic       out_error,
  output logic       board_done,
  output logic [4:0] solved_count,
  output logic       board_solved
);

  logic       inFire;
  logic       outFire;
  logic [3:0] cellCount;
  logic [3:0] encDigit;

  // The output register may reload in the same cycle it is drained.
  assign in_ready = !out_valid || out_ready;
  assign inFire   = in_valid && in_ready;
  assign outFire  = out_valid && out_ready;

  always_comb begin
    encDigit = 4'd0;
    case (in_mask)
      4'b0001: encDigit = 4'd1;
      4'b0010: encDigit = 4'd2;
      4'b0100: encDigit = 4'd3;
      4'b1000: encDigit = 4'd4;
      default: encDigit = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_digit <= 4'd0;
      out_cell  <= 4'd0;
      out_error <= 1'b0;
      cellCount <= 4'd0;
    end else begin
      if (inFire) begin
        out_valid <= 1'b1;
        out_digit <= encDigit;
        out_cell  <= cellCount;
        out_error <= (in_mask == 4'b0000);
        cellCount <= cellCount + 4'd1;
      end else if (outFire) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MASK_ENCODER_BOARD_STATS_EN
  typedef enum logic {FILL, LAST} boardState_t;

  boardState_t state;
  boardState_t nextState;
  logic [4:0]  runCount;
  logic [4:0]  finalCount;
  logic        errFlag;
  logic        boardEnd;
  logic        cellOneHot;

  // Statistics are taken at the output side so only delivered cells count.
  assign cellOneHot = (out_digit != 4'd0);
  assign boardEnd   = outFire && (state == LAST) && (out_cell == 4'd15);
  assign finalCount = runCount + {4'd0, cellOneHot};

  always_comb begin
    nextState = state;
    case (state)
      FILL:    if (inFire && (cellCount == 4'd15)) nextState = LAST;
      LAST:    if (boardEnd) nextState = FILL;
      default: nextState = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      runCount     <= 5'd0;
      errFlag      <= 1'b0;
      board_done   <= 1'b0;
      solved_count <= 5'd0;
      board_solved <= 1'b0;
    end else begin
      state      <= nextState;
      board_done <= boardEnd;
      if (boardEnd) begin
        solved_count <= finalCount;
        board_solved <= (finalCount == 5'd16) && !errFlag && !out_error;
        runCount     <= 5'd0;
        errFlag      <= 1'b0;
      end else if (outFire) begin
        runCount <= finalCount;
        errFlag  <= errFlag || out_error;
      end
    end
  end
`else
  assign board_done   = 1'b0;
  assign solved_count = 5'd0;
  assign board_solved = 1'b0;
`endif

endmodule

// File: tb/tb_mask_encoder.sv
// Directed, table-driven bench for mask_encoder: encoding, handshake, cell tagging and board statistics.
module tb_mask_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_mask;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic [3:0] out_cell;
  logic       out_error;
  logic       board_done;
  logic [4:0] solved_count;
  logic       board_solved;

`ifdef MASK_ENCODER_BOARD_STATS_EN
  localparam bit statsEn = 1'b1;
`else
  localparam bit statsEn = 1'b0;
`endif

  typedef struct {
    logic [3:0] mask;
    logic [3:0] expDigit;
    logic       expError;
  } vec_t;

  vec_t encTable[16];
  vec_t stream[32];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   doneCount;

  mask_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mask(in_mask),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_digit(out_digit), .out_cell(out_cell), .out_error(out_error),
    .board_done(board_done), .solved_count(solved_count), .board_solved(board_solved)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [3:0] m, input logic r);
    in_valid  = v;
    in_mask   = m;
    out_ready = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Statistics outputs read zero unless the board-stats build is selected.
  task automatic checkStats(input string name, input logic expDone, input logic [4:0] expCount,
                            input logic expSolved);
    checkOutput({name, "_done"}, {31'd0, board_done}, {31'd0, expDone & statsEn});
    checkOutput({name, "_count"}, {27'd0, solved_count}, statsEn ? {27'd0, expCount} : 32'd0);
    checkOutput({name, "_solved"}, {31'd0, board_solved}, {31'd0, expSolved & statsEn});
  endtask

  initial begin
    encTable[0]  = '{4'b0000, 4'd0, 1'b1};
    encTable[1]  = '{4'b0001, 4'd1, 1'b0};
    encTable[2]  = '{4'b0010, 4'd2, 1'b0};
    encTable[3]  = '{4'b0011, 4'd0, 1'b0};
    encTable[4]  = '{4'b0100, 4'd3, 1'b0};
    encTable[5]  = '{4'b0101, 4'd0, 1'b0};
    encTable[6]  = '{4'b0110, 4'd0, 1'b0};
    encTable[7]  = '{4'b0111, 4'd0, 1'b0};
    encTable[8]  = '{4'b1000, 4'd4, 1'b0};
    encTable[9]  = '{4'b1001, 4'd0, 1'b0};
    encTable[10] = '{4'b1010, 4'd0, 1'b0};
    encTable[11] = '{4'b1011, 4'd0, 1'b0};
    encTable[12] = '{4'b1100, 4'd0, 1'b0};
    encTable[13] = '{4'b1101, 4'd0, 1'b0};
    encTable[14] = '{4'b1110, 4'd0, 1'b0};
    encTable[15] = '{4'b1111, 4'd0, 1'b0};

    // First board all one-hot, second board 12 one-hot + 3 multi-bit + 1 empty.
    for (int i = 0; i < 16; i++) begin
      stream[i] = '{4'b0001 << (i % 4), 4'((i % 4) + 1), 1'b0};
    end
    for (int j = 0; j < 12; j++) begin
      stream[16 + j] = '{4'b0001 << (j % 4), 4'((j % 4) + 1), 1'b0};
    end
    stream[28] = '{4'b0011, 4'd0, 1'b0};
    stream[29] = '{4'b0000, 4'd0, 1'b1};
    stream[30] = '{4'b0110, 4'd0, 1'b0};
    stream[31] = '{4'b1111, 4'd0, 1'b0};

    // Reset state
    doReset();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_digit", {28'd0, out_digit}, 32'd0);
    checkOutput("rst_out_cell", {28'd0, out_cell}, 32'd0);
    checkOutput("rst_out_error", {31'd0, out_error}, 32'd0);
    checkStats("rst", 1'b0, 5'd0, 1'b0);

    // Single cell latency
    applyStimulus(1'b1, 4'b0100, 1'b1);
    tick();
    checkOutput("first_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("first_digit", {28'd0, out_digit}, 32'd3);
    checkOutput("first_cell", {28'd0, out_cell}, 32'd0);
    checkOutput("first_error", {31'd0, out_error}, 32'd0);

    // Every mask value as one full board
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, encTable[i].mask, 1'b1);
      tick();
      checkOutput("enc_valid", {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("enc_digit_%0d", i), {28'd0, out_digit}, {28'd0, encTable[i].expDigit});
      checkOutput($sformatf("enc_error_%0d", i), {31'd0, out_error}, {31'd0, encTable[i].expError});
      checkOutput($sformatf("enc_cell_%0d", i), {28'd0, out_cell}, i);
      checkOutput("enc_no_done", {31'd0, board_done}, 32'd0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkOutput("enc_drain_valid", {31'd0, out_valid}, 32'd0);
    checkStats("enc_end", 1'b1, 5'd4, 1'b0);
    tick();
    checkStats("enc_hold", 1'b0, 5'd4, 1'b0);

    // Two boards back to back, wrapping the cell counter
    doReset();
    doneCount = 0;
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) applyStimulus(1'b1, stream[i].mask, 1'b1);
      else        applyStimulus(1'b0, 4'b0000, 1'b1);
      tick();
      if (board_done) doneCount++;
      checkOutput($sformatf("strm_done_%0d", i), {31'd0, board_done},
                  {31'd0, statsEn && (i == 16 || i == 32)});
      if (i < 32) begin
        checkOutput($sformatf("strm_cell_%0d", i), {28'd0, out_cell}, i % 16);
        checkOutput($sformatf("strm_digit_%0d", i), {28'd0, out_digit}, {28'd0, stream[i].expDigit});
        checkOutput($sformatf("strm_error_%0d", i), {31'd0, out_error}, {31'd0, stream[i].expError});
      end
      if (i == 16) checkStats("board1", 1'b1, 5'd16, 1'b1);
      if (i == 32) checkStats("board2", 1'b1, 5'd12, 1'b0);
    end
    checkOutput("strm_done_pulses", doneCount, statsEn ? 32'd2 : 32'd0);

    // Backpressure: stall three cycles, changing in_mask must not be taken
    doReset();
    applyStimulus(1'b1, 4'b0001, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 4'b1000, 1'b0);
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_digit", {28'd0, out_digit}, 32'd1);
      checkOutput("stall_cell", {28'd0, out_cell}, 32'd0);
    end
    applyStimulus(1'b1, 4'b0010, 1'b1);
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("release_digit", {28'd0, out_digit}, 32'd2);
    checkOutput("release_cell", {28'd0, out_cell}, 32'd1);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    tick();
    checkOutput("after_digit", {28'd0, out_digit}, 32'd3);
    checkOutput("after_cell", {28'd0, out_cell}, 32'd2);
    applyStimulus(1'b0, 4'bxxxx, 1'b1);
    tick();
    checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("idle_still_empty", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b1, 4'b1000, 1'b1);
    tick();
    checkOutput("resume_digit", {28'd0, out_digit}, 32'd4);
    checkOutput("resume_cell", {28'd0, out_cell}, 32'd3);

    // Reset mid-board after cell 7
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'b0001, 1'b1);
      tick();
    end
    checkOutput("mid_cell7", {28'd0, out_cell}, 32'd7);
    reset = 1'b1;
    applyStimulus(1'b1, 4'b0010, 1'b1);
    tick();
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkStats("mid_rst", 1'b0, 5'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, 4'b0010, 1'b1);
    tick();
    checkOutput("mid_next_cell", {28'd0, out_cell}, 32'd0);
    checkOutput("mid_next_digit", {28'd0, out_digit}, 32'd2);
    checkOutput("mid_next_done", {31'd0, board_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
